axi_rd_slave: RTL and testbench
===============================

// Module: axi_rd_slave
// PURPOSE
//  AXI3 read-channel responder (AR accept + R return), the slave end of the bridge's AR/R master channels.
//  Backs a word-addressed synchronous memory; used as the bench/SoC memory model for the CPU AXI bridge.
//  Queues up to QDEPTH read requests and returns beats in request order (no reordering across IDs).
// PARAMETERS
//  MEM_AW  10  word-address width; memory holds 2**MEM_AW 32-bit words at byte base 0
//  QDEPTH   2  AR request queue depth (power of 2, >=2); matches the bridge's two read IDs (inst/data)
// PORTS
//  clk       in   1   clock, all logic on rising edge
//  resetn    in   1   synchronous active-low reset
//  arid      in   4   request ID, echoed on rid
//  araddr    in  32   byte address of first beat
//  arlen     in   8   beats-1
//  arsize    in   3   bytes/beat = 1<<arsize (0..2 legal)
//  arburst   in   2   00 FIXED, 01 INCR, 10 WRAP
//  arlock/arcache/arprot in 2/4/3  accepted, ignored
//  arvalid   in   1   request valid
//  arready   out  1   request accept
//  rid       out  4   ID of current beat
//  rdata     out 32   full word at beat_addr[MEM_AW+1:2]; master picks lanes
//  rresp     out  2   00 OKAY, 11 DECERR
//  rlast     out  1   final beat of burst
//  rvalid    out  1   beat valid
//  rready    in   1   beat accept
//  bd_we/bd_addr/bd_wdata in 1/MEM_AW/32  backdoor word write for preload, takes effect next edge
// BEHAVIOUR
//  Reset: arready=0 during reset, 1 first cycle after; rvalid=0, rlast=0, rid=0, rdata=0, rresp=0; queue emptied, FSM IDLE.
//  Reset mid-burst: in-flight and queued requests dropped, no further beats; memory contents kept.
//  AR: arready = !queue_full (registered-state only). Handshake arvalid&&arready pushes {arid,araddr,arlen,arsize,arburst}.
//  Full queue: arready=0 even if a pop occurs the same cycle (no push-through on full).
//  FSM states IDLE -> RD -> RESP:
//   IDLE: queue non-empty -> load head into burst regs, beat_cnt=0 -> RD.
//   RD: memory read of beat_addr issued; next edge capture data into rdata reg -> RESP.
//   RESP: rvalid=1; rid,rdata,rresp,rlast held stable while !rready.
//     rvalid&&rready && !rlast -> advance beat_addr, beat_cnt+1 -> RD.
//     rvalid&&rready && rlast  -> pop queue -> IDLE.
//  Latency: AR handshake at edge E -> rvalid first high after edge E+3; burst beats every 2 cycles min with rready=1.
//  rlast = (beat_cnt == len). len=0 gives a single beat with rlast=1.
//  Address step per beat = 1<<size: FIXED no step; INCR addr+step (32-bit wrap at 2**32);
//   WRAP: boundary=(len+1)*step, addr = (addr & ~(boundary-1)) | ((addr+step) & (boundary-1)); len+1 in {2,4,8,16}, else treated as INCR.
//  DECERR when beat_addr >= 4*2**MEM_AW: rresp=11, rdata=0, memory not read; burst continues to len.
//  arsize>2: every beat of that burst DECERR.
//  bd_we same cycle as an RD read of same word: read returns old data.
// CONFIGURATION
//  AXI_RD_STALL_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances each cycle;
//   arready additionally gated by lfsr[0]; RD->RESP delayed while lfsr[1]=0. Handshake rules unchanged.
//  Undefined: no stalls, latencies exactly as above.
// STRUCTURE
//  Shared header axi_defs.vh: BURST_FIXED/INCR/WRAP, RESP_OKAY/DECERR, FSM state encodings.
//  One sub-module: axi_rd_req_fifo (sync FIFO, QDEPTH entries, full/empty, push/pop).
//  Memory is an inferred reg array in this module.
// TESTING
//  Preload mem[4]=32'h1234_5678; AR id=1,addr=0x10,len=0,size=2 -> one beat rid=1,rdata=32'h1234_5678,rresp=00,rlast=1, rvalid at E+3.
//  INCR len=3 addr=0x0, words 0..3 = 0xA0..0xA3, rready=1 -> 4 beats 0xA0..0xA3, rlast only on 4th, beats 2 cycles apart.
//  WRAP len=3 size=2 addr=0x08 -> beat addresses 0x08,0x0C,0x00,0x04; FIXED len=2 addr=0x08 -> word 2 returned thrice.
//  Three back-to-back ARs (ids 0,1,0) with rready=0 -> first two accepted, arready=0 for third until first burst's rlast handshake.
//  addr=4*2**MEM_AW, len=1 -> two beats rresp=11, rdata=0, rlast on 2nd; rready toggled 0/1 -> outputs stable while stalled.
//  resetn=0 for 1 cycle during beat 2 of len=3 burst -> rvalid=0 next cycle, no more beats; new AR afterwards served normally.

Source files
------------

// File: rtl/axi_rd_slave_pkg.sv
// Shared AXI3 read-channel definitions: burst/response codes, FSM states,
// queued request record and the per-beat address step.
package axi_rd_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_RESP
    } rd_state_e;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_req_t;

    // WRAP with a burst length other than 2/4/8/16 falls back to INCR stepping.
    function automatic logic [31:0] next_beat_addr(input logic [31:0] addr,
                                                   input logic [7:0]  len,
                                                   input logic [2:0]  size,
                                                   input logic [1:0]  burst);
        logic [31:0] step;
        logic [31:0] bound;
        logic [31:0] nxt;
        step  = 32'd1 << size;
        bound = (32'(len) + 32'd1) * step;
        nxt   = addr + step;
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_INCR:  nxt = addr + step;
            BURST_WRAP: begin
                if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
                    nxt = (addr & ~(bound - 32'd1)) | ((addr + step) & (bound - 32'd1));
            end
            default:     nxt = addr + step;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/axi_rd_req_fifo.sv
// Synchronous FIFO holding accepted AR requests until their burst completes.
module axi_rd_req_fifo
    import axi_rd_slave_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    resetn,
    input  logic    push,
    input  ar_req_t din,
    input  logic    pop,
    output ar_req_t dout,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    ar_req_t        slots [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_rd_slave.sv
// AXI3 read slave backed by a word-addressed memory; in-order bursts from a request queue.
// Define AXI_RD_STALL_EN to add LFSR-driven AR and R back-pressure.
module axi_rd_slave
    import axi_rd_slave_pkg::*;
#(
    parameter int unsigned MEM_AW = 10,
    parameter int unsigned QDEPTH = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic              bd_we,
    input  logic [MEM_AW-1:0] bd_addr,
    input  logic [31:0]       bd_wdata
);

    localparam int unsigned MEM_WORDS = 1 << MEM_AW;

    logic [31:0] mem [MEM_WORDS];

    rd_state_e   st;
    ar_req_t     q_head;
    ar_req_t     req_in;
    logic        q_full, q_empty, q_push, q_pop;
    logic        ready_en, q_avail, rd_go, beat_err;
    logic [3:0]  b_id;
    logic [31:0] b_addr;
    logic [7:0]  b_len, beat_cnt;
    logic [2:0]  b_size;
    logic [1:0]  b_burst;
    logic        unused_ok;

    assign unused_ok = ^{arlock, arcache, arprot};
    assign req_in    = {arid, araddr, arlen, arsize, arburst};
    assign q_push    = arvalid && arready;
    assign q_pop     = (st == ST_RESP) && rready && rlast;
    assign beat_err  = (b_size > 3'd2) || (b_addr[31:MEM_AW+2] != '0);
    assign rid       = b_id;

`ifdef AXI_RD_STALL_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (!resetn) lfsr <= 8'hA5;
        else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign arready = ready_en && !q_full && lfsr[0];
    assign rd_go   = lfsr[1];
`else
    assign arready = ready_en && !q_full;
    assign rd_go   = 1'b1;
`endif

    axi_rd_req_fifo #(.DEPTH(QDEPTH)) u_req_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (q_push),
        .din    (req_in),
        .pop    (q_pop),
        .dout   (q_head),
        .full   (q_full),
        .empty  (q_empty)
    );

    always_ff @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_wdata;
    end

    // Queue occupancy is seen one cycle late; masking it on the pop edge keeps
    // IDLE from reloading the entry that is being retired.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            st       <= ST_IDLE;
            ready_en <= 1'b0;
            q_avail  <= 1'b0;
            b_id     <= '0;
            b_addr   <= '0;
            b_len    <= '0;
            b_size   <= '0;
            b_burst  <= '0;
            beat_cnt <= '0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
        end else begin
            ready_en <= 1'b1;
            q_avail  <= !q_empty && !q_pop;
            case (st)
                ST_IDLE: begin
                    if (q_avail) begin
                        b_id     <= q_head.id;
                        b_addr   <= q_head.addr;
                        b_len    <= q_head.len;
                        b_size   <= q_head.size;
                        b_burst  <= q_head.burst;
                        beat_cnt <= '0;
                        st       <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (rd_go) begin
                        rvalid <= 1'b1;
                        rlast  <= (beat_cnt == b_len);
                        if (beat_err) begin
                            rresp <= RESP_DECERR;
                            rdata <= '0;
                        end else begin
                            rresp <= RESP_OKAY;
                            rdata <= mem[b_addr[MEM_AW+1:2]];
                        end
                        st <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        if (rlast) begin
                            st <= ST_IDLE;
                        end else begin
                            b_addr   <= next_beat_addr(b_addr, b_len, b_size, b_burst);
                            beat_cnt <= beat_cnt + 8'd1;
                            st       <= ST_RD;
                        end
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_slave.sv
// Randomized bench for axi_rd_slave against a queue-based burst model.
module tb_axi_rd_slave;

    localparam int unsigned MEM_AW    = 10;
    localparam int unsigned QDEPTH    = 2;
    localparam int unsigned MEM_WORDS = 1 << MEM_AW;
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic              clk, resetn;
    logic [3:0]        arid;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid, arready;
    logic [3:0]        rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast, rvalid, rready;
    logic              bd_we;
    logic [MEM_AW-1:0] bd_addr;
    logic [31:0]       bd_wdata;

    axi_rd_slave #(.MEM_AW(MEM_AW), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int occ   = 0;
    int rr_mode = 0;
    bit prev_rstn = 1'b0;
    bit hold_vld = 1'b0;
    logic [39:0] hold_val;
    beat_t exp_q[$];
    int    beat_cyc[$];
    bit    beat_last[$];
    logic [31:0] mdl_mem [MEM_WORDS];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Beat i lands at start + i*step; WRAP folds that offset modulo the wrap window.
    task automatic gen_beats(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        int unsigned nb, step, bound;
        logic [31:0] a, base;
        bit wrap;
        beat_t b;
        nb    = int'(len) + 1;
        step  = 1 << size;
        bound = nb * step;
        wrap  = (burst == 2'b10) && (nb == 2 || nb == 4 || nb == 8 || nb == 16);
        base  = addr - (addr % bound);
        for (int unsigned i = 0; i < nb; i++) begin
            if (burst == 2'b00)  a = addr;
            else if (wrap)       a = base + (((addr - base) + i * step) % bound);
            else                 a = addr + i * step;
            b.id   = id;
            b.last = (i == nb - 1);
            if (size > 3'd2 || a >= MEM_BYTES) begin
                b.resp = 2'b11;
                b.data = '0;
            end else begin
                b.resp = 2'b00;
                b.data = mdl_mem[a[MEM_AW+1:2]];
            end
            exp_q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            occ      = 0;
            hold_vld = 1'b0;
        end else begin
            if (prev_rstn) chk("arready", 64'(arready), 64'(occ < QDEPTH));
            else           chk("rst_out", 64'({rvalid, rlast, rid, rdata, rresp}), 64'(0));
            if (hold_vld) chk("r_hold", 64'({rvalid, rid, rdata, rresp, rlast}), 64'(hold_val));
            hold_vld = rvalid && !rready;
            hold_val = {rvalid, rid, rdata, rresp, rlast};
            if (rvalid && rready) begin
                chk("beat_avail", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat", 64'({rid, rresp, rlast, rdata}), 64'({e.id, e.resp, e.last, e.data}));
                end
                beat_cyc.push_back(cyc);
                beat_last.push_back(rlast);
                if (rlast) occ--;
            end
            if (arvalid && arready) begin
                gen_beats(arid, araddr, arlen, arsize, arburst);
                occ++;
            end
        end
        prev_rstn = resetn;
    end

    initial begin
        rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       rready = 1'b0;
                1:       rready = 1'b1;
                default: rready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic bd_write(input int unsigned idx, input logic [31:0] val);
        bd_we    = 1'b1;
        bd_addr  = MEM_AW'(idx);
        bd_wdata = val;
        mdl_mem[idx] = val;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output int hs);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        hs = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (arready) begin
                hs = cyc;
                break;
            end
        end
        chk("ar_accept", 64'(hs >= 0), 64'(1));
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic drain(input int limit);
        for (int k = 0; k < limit; k++) begin
            if (exp_q.size() == 0 && occ == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain", 64'(exp_q.size() + occ), 64'(0));
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        int hs, lat, c, rl, n_before;
        resetn = 1'b0;
        arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arlock = '0; arcache = '0; arprot = '0;
        bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_arready", 64'(arready), 64'(0));
        chk("rst_rvalid",  64'(rvalid), 64'(0));
        chk("rst_fields",  64'({rid, rdata, rresp, rlast}), 64'(0));
        @(posedge clk); #1; resetn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("arready_after_rst", 64'(arready), 64'(1));
        @(posedge clk); #1;

        for (int unsigned i = 0; i < MEM_WORDS; i++) bd_write(i, $urandom);
        for (int unsigned i = 0; i < 4; i++) bd_write(i, 32'hA0 + i);
        bd_write(4, 32'h1234_5678);
        rr_mode = 1;

        ar_send(4'd1, 32'h10, 8'd0, 3'd2, 2'b01, hs);
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rvalid) begin
                lat = cyc - (hs + 1);
                chk("single_data", 64'({rid, rresp, rlast, rdata}), 64'({4'd1, 2'b00, 1'b1, 32'h1234_5678}));
                break;
            end
        end
        chk("single_latency", 64'(lat), 64'(3));
        @(posedge clk); #1;
        drain(100);

        beat_cyc.delete(); beat_last.delete();
        ar_send(4'd2, 32'h0, 8'd3, 3'd2, 2'b01, hs);
        drain(100);
        chk("incr_beats", 64'(beat_cyc.size()), 64'(4));
        for (int i = 1; i < beat_cyc.size(); i++) chk("incr_gap", 64'(beat_cyc[i] - beat_cyc[i-1]), 64'(2));
        foreach (beat_last[i]) chk("incr_last", 64'(beat_last[i]), 64'(i == 3));

        ar_send(4'd3, 32'h08, 8'd3, 3'd2, 2'b10, hs);
        drain(100);
        ar_send(4'd4, 32'h08, 8'd2, 3'd2, 2'b00, hs);
        drain(100);
        ar_send(4'd9, 32'hFFFF_FFF8, 8'd3, 3'd2, 2'b01, hs);
        drain(100);

        rr_mode = 0;
        beat_cyc.delete(); beat_last.delete();
        ar_send(4'd0, 32'h20, 8'd1, 3'd2, 2'b01, hs);
        ar_send(4'd1, 32'h30, 8'd1, 3'd2, 2'b01, hs);
        arid = 4'd0; araddr = 32'h50; arlen = 8'd1; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("ar3_blocked", 64'(arready), 64'(0));
        end
        @(posedge clk); #1; rr_mode = 1;
        c = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (arready) begin c = cyc; break; end
        end
        chk("ar3_accept", 64'(c >= 0), 64'(1));
        @(posedge clk); #1; arvalid = 1'b0;
        rl = -1;
        foreach (beat_last[i]) if (beat_last[i] && rl < 0) rl = beat_cyc[i];
        chk("ar3_after_pop", 64'(rl >= 0 && c > rl), 64'(1));
        drain(200);

        rr_mode = 2;
        beat_cyc.delete(); beat_last.delete();
        ar_send(4'd5, MEM_BYTES, 8'd1, 3'd2, 2'b01, hs);
        drain(200);
        chk("decerr_beats", 64'(beat_cyc.size()), 64'(2));

        rr_mode = 1;
        beat_cyc.delete(); beat_last.delete();
        ar_send(4'd6, 32'h40, 8'd3, 3'd2, 2'b01, hs);
        for (int k = 0; k < 40; k++) begin
            if (beat_cyc.size() >= 1) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1; resetn = 1'b0;
        @(posedge clk); #1; resetn = 1'b1;
        n_before = beat_cyc.size();
        repeat (12) begin @(posedge clk); #1; end
        chk("no_beats_after_rst", 64'(beat_cyc.size()), 64'(n_before));
        ar_send(4'd7, 32'h10, 8'd0, 3'd2, 2'b01, hs);
        drain(100);

        rr_mode = 2;
        for (int n = 0; n < 60; n++) begin
            logic [7:0]  len;
            logic [2:0]  size;
            logic [31:0] addr;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            case ($urandom_range(0, 5))
                0:       len = 8'd0;
                1:       len = 8'd1;
                2:       len = 8'd3;
                3:       len = 8'd7;
                4:       len = 8'd15;
                default: len = 8'($urandom_range(0, 15));
            endcase
            size = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(4000, 4300))
                                               : 32'($urandom_range(0, 4095));
            ar_send(4'($urandom_range(0, 15)), addr, len, size, 2'($urandom_range(0, 2)), hs);
        end
        drain(4000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
